// File: rtl/interleave_pkg.sv
// Shared definitions for the interleave_tx slice: FSM state encoding and
// default frame geometry.
package interleave_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int DW_DEF   = 6;
    localparam int NCH_DEF  = 4;
    localparam int NFRM_DEF = 4;

endpackage

// File: rtl/interleave_fifo.sv
// Synchronous frame FIFO for interleave_tx: DEPTH entries of W bits with an
// occupancy count, a registered ready flag and a look-ahead read port.
module interleave_fifo #(
    parameter int  W     = 24,
    parameter int  DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wr_data,
    output logic [W-1:0]  rd_data,
    output logic [W-1:0]  rd_data_next,
    output logic [CW-1:0] count,
    output logic          ready
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_n;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        // NOTE: assign a default first so every path drives count_n and no latch is inferred.
        count_n = count;
        case ({push, pop})
            2'b10:   count_n = count + 1'b1;
            2'b01:   count_n = count - 1'b1;
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register here samples pre-edge values.
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            count <= count_n;
            ready <= (count_n < CW'(DEPTH));
        end
    end

    // NOTE: storage is not reset; count alone decides which entries hold valid frames.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data      = mem[rd_ptr];
    assign rd_data_next = mem[bump(rd_ptr)];

endmodule

// File: rtl/interleave_tx.sv
// Buffers NCH-channel frames and emits bursts of NFRM frames one channel slot
// per cycle. Define INTERLEAVE_TX_STAT_EN to add the burst_cnt statistics port.
module interleave_tx
    import interleave_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int NCH   = NCH_DEF,
    parameter int NFRM  = NFRM_DEF,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NCH*DW-1:0] in_data,
    output logic [DW-1:0]     dout,
    output logic              en,
    output logic              busy
`ifdef INTERLEAVE_TX_STAT_EN
    ,
    output logic [15:0]       burst_cnt
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int FW = (NFRM > 1) ? $clog2(NFRM) : 1;

    state_t             state, state_n;
    logic [SW-1:0]      slot, slot_n;
    logic [FW-1:0]      frm, frm_n;
    logic [CW-1:0]      count;
    logic [NCH*DW-1:0]  head, head_next, src;
    logic [DW-1:0]      dout_n;
    logic               en_n, accept, pop, burst_ok, last_slot, last_frm;

    assign accept    = in_valid & in_ready;
    assign burst_ok  = (count >= CW'(NFRM));
    assign last_slot = (slot == SW'(NCH - 1));
    assign last_frm  = (frm == FW'(NFRM - 1));

    interleave_fifo #(
        .W     (NCH * DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (accept),
        .pop          (pop),
        .wr_data      (in_data),
        .rd_data      (head),
        .rd_data_next (head_next),
        .count        (count),
        .ready        (in_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            slot  <= '0;
            frm   <= '0;
            en    <= 1'b0;
            dout  <= '0;
        end else begin
            state <= state_n;
            slot  <= slot_n;
            frm   <= frm_n;
            en    <= en_n;
            dout  <= dout_n;
        end
    end

    always_comb begin
        state_n = state;
        slot_n  = slot;
        frm_n   = frm;
        unique case (state)
            IDLE: begin
                if (burst_ok) begin
                    state_n = SEND;
                    slot_n  = '0;
                    frm_n   = '0;
                end
            end
            SEND: begin
                if (last_slot) begin
                    slot_n = '0;
                    if (last_frm) begin
                        state_n = GAP;
                        frm_n   = '0;
                    end else begin
                        frm_n = frm + 1'b1;
                    end
                end else begin
                    slot_n = slot + 1'b1;
                end
            end
            GAP:     state_n = burst_ok ? SEND : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // dout/en are loaded with next-cycle values; after a pop the head has
    // already advanced, so the look-ahead frame is the source.
    always_comb begin
        pop    = (state == SEND) && last_slot;
        busy   = (state != IDLE);
        src    = pop ? head_next : head;
        en_n   = (state_n == SEND);
        dout_n = en_n ? src[int'(slot_n)*DW +: DW] : '0;
    end

`ifdef INTERLEAVE_TX_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= '0;
        end else if (state == GAP) begin
            burst_cnt <= burst_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_interleave_tx.sv
// Directed self-checking bench for interleave_tx (DEPTH=8 so two bursts can
// run back-to-back); the stats test is built only with INTERLEAVE_TX_STAT_EN.
module tb_interleave_tx;

    localparam int DW    = 6;
    localparam int NCH   = 4;
    localparam int NFRM  = 4;
    localparam int DEPTH = 8;
    localparam int FWD   = NCH * DW;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [FWD-1:0] in_data;
    logic [DW-1:0]  dout;
    logic           en;
    logic           busy;
`ifdef INTERLEAVE_TX_STAT_EN
    logic [15:0]    burst_cnt;
`endif

    int tests = 0;
    int fails = 0;
    logic [FWD-1:0] exp_frames [NFRM];

    interleave_tx #(
        .DW    (DW),
        .NCH   (NCH),
        .NFRM  (NFRM),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .dout     (dout),
        .en       (en),
        .busy     (busy)
`ifdef INTERLEAVE_TX_STAT_EN
        ,
        .burst_cnt(burst_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [FWD-1:0] mk(input int a, input int b, input int c, input int d);
        return {DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    // Frame n carries channel values 4n-3 .. 4n (ch0 first on dout).
    function automatic logic [FWD-1:0] frame(input int n);
        return mk(4*n - 3, 4*n - 2, 4*n - 1, 4*n);
    endfunction

    task automatic set_exp(input int first);
        for (int f = 0; f < NFRM; f++) exp_frames[f] = frame(first + f);
    endtask

    // Called at a negedge; returns at the negedge after the frame was taken.
    task automatic push_one(input logic [FWD-1:0] f);
        int n = 0;
        in_valid = 1'b1;
        in_data  = f;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL push_wait: in_ready=%b after %0d cycles, want 1", in_ready, n);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Checks one full burst against exp_frames, ending at the GAP negedge.
    task automatic collect_burst(input string tag);
        int n = 0;
        logic [DW-1:0] e;
        while (!en && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (en !== 1'b1) begin
            fails++;
            $display("FAIL %s_start: en=%b after %0d cycles, want 1", tag, en, n);
        end
        for (int i = 0; i < NCH*NFRM; i++) begin
            e = exp_frames[i / NCH][(i % NCH)*DW +: DW];
            tests++;
            if (en !== 1'b1 || dout !== e) begin
                fails++;
                $display("FAIL %s_slot%0d: en=%b dout=%0d, want en=1 dout=%0d", tag, i, en, dout, e);
            end
            @(negedge clk);
        end
        tests++;
        if (en !== 1'b0 || dout !== '0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL %s_gap: en=%b dout=%0d busy=%b, want en=0 dout=0 busy=1", tag, en, dout, busy);
        end
    endtask

    task automatic check_idle(input string tag);
        tests++;
        if (busy !== 1'b0 || en !== 1'b0 || dout !== '0) begin
            fails++;
            $display("FAIL %s_idle: busy=%b en=%b dout=%0d, want 0 0 0", tag, busy, en, dout);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (en !== 1'b0 || dout !== '0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: en=%b dout=%0d busy=%b in_ready=%b, want all 0", en, dout, busy, in_ready);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_no_edge: in_ready=%b, want 0", in_ready);
        end
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready_rise: in_ready=%b, want 1", in_ready);
        end
    endtask

    task automatic test_single_burst();
        for (int f = 0; f < NFRM; f++) exp_frames[f] = mk(1, 2, 3, 4);
        for (int k = 0; k < 3; k++) begin
            push_one(mk(1, 2, 3, 4));
            check_idle($sformatf("three_push%0d", k));
        end
        repeat (3) @(negedge clk);
        check_idle("three_hold");
        push_one(mk(1, 2, 3, 4));
        tests++;
        if (en !== 1'b0) begin
            fails++;
            $display("FAIL fourth_push_latency: en=%b on push cycle, want 0", en);
        end
        @(negedge clk);
        tests++;
        if (en !== 1'b1) begin
            fails++;
            $display("FAIL fourth_push_en_rise: en=%b, want 1", en);
        end
        collect_burst("single");
        @(negedge clk);
        check_idle("single_after_gap");
    endtask

    task automatic test_back_to_back();
        set_exp(1);
        fork
            begin
                for (int n = 1; n <= 8; n++) push_one(frame(n));
            end
            begin
                collect_burst("b2b_a");
                set_exp(5);
                @(negedge clk);
                tests++;
                if (en !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_one_gap: en=%b after gap cycle, want 1", en);
                end
                collect_burst("b2b_b");
                @(negedge clk);
                check_idle("b2b_end");
            end
        join
    endtask

    task automatic test_full();
        set_exp(1);
        fork
            begin
                for (int n = 1; n <= 8; n++) push_one(frame(n));
                tests++;
                if (in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL full_ready_low: in_ready=%b, want 0", in_ready);
                end
                in_valid = 1'b1;
                in_data  = frame(9);
                @(negedge clk);
                tests++;
                if (in_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL full_pop_frees_next: in_ready=%b, want 1", in_ready);
                end
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = '0;
                tests++;
                if (in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL full_refilled: in_ready=%b, want 0", in_ready);
                end
            end
            begin
                collect_burst("full_a");
                set_exp(5);
                collect_burst("full_b");
                @(negedge clk);
                check_idle("full_one_left");
            end
        join
        for (int n = 10; n <= 12; n++) push_one(frame(n));
        set_exp(9);
        collect_burst("full_c");
        @(negedge clk);
        check_idle("full_end");
    endtask

    task automatic test_reset_mid_burst();
        bit saw_en = 1'b0;
        set_exp(1);
        for (int n = 1; n <= 4; n++) push_one(frame(n));
        for (int n = 0; n < 20 && !en; n++) @(negedge clk);
        repeat (6) @(negedge clk);
        tests++;
        if (en !== 1'b1 || dout !== DW'(7)) begin
            fails++;
            $display("FAIL midrst_pre: en=%b dout=%0d, want en=1 dout=7", en, dout);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (en !== 1'b0 || dout !== '0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL midrst_async: en=%b dout=%0d busy=%b in_ready=%b, want all 0", en, dout, busy, in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL midrst_ready: in_ready=%b, want 1", in_ready);
        end
        for (int n = 0; n < 40; n++) begin
            if (en || busy) saw_en = 1'b1;
            @(negedge clk);
        end
        tests++;
        if (saw_en !== 1'b0) begin
            fails++;
            $display("FAIL midrst_stale_burst: en/busy seen=%b, want 0", saw_en);
        end
        set_exp(5);
        for (int n = 5; n <= 8; n++) push_one(frame(n));
        collect_burst("midrst_after");
        @(negedge clk);
        check_idle("midrst_end");
    endtask

`ifdef INTERLEAVE_TX_STAT_EN
    task automatic test_stats();
        apply_reset();
        tests++;
        if (burst_cnt !== 16'd0) begin
            fails++;
            $display("FAIL stat_reset: burst_cnt=%0d, want 0", burst_cnt);
        end
        for (int b = 0; b < 3; b++) begin
            set_exp(1);
            for (int n = 1; n <= 4; n++) push_one(frame(n));
            collect_burst($sformatf("stat%0d", b));
            @(negedge clk);
        end
        tests++;
        if (burst_cnt !== 16'd3) begin
            fails++;
            $display("FAIL stat_three: burst_cnt=%0d, want 3", burst_cnt);
        end
        force dut.burst_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.burst_cnt;
        set_exp(2);
        for (int n = 2; n <= 5; n++) push_one(frame(n));
        collect_burst("stat_wrap");
        @(negedge clk);
        tests++;
        if (burst_cnt !== 16'd0) begin
            fails++;
            $display("FAIL stat_wrap: burst_cnt=%0h, want 0", burst_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_full();
        test_reset_mid_burst();
`ifdef INTERLEAVE_TX_STAT_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
